// File: rtl/demux_1_4_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : demux_1_4_rr_ctrl
// Brief    : Round-robin dispatcher driving 1x4 demux selects from a one-word
//            holding register. Optional per-channel counters: DEMUX_RR_CNT_EN.
// Revision : 1.0
// ============================================================================
module demux_1_4_rr_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       ch_en,
    input  logic [3:0]       out_ready,
    output logic [3:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             s0,
    output logic             s1,
    output logic             busy
`ifdef DEMUX_RR_CNT_EN
    ,
    output logic [31:0]      cnt
`endif
);

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_SEND = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [1:0]       sel_q,   sel_d;
    logic [1:0]       last_q,  last_d;

    logic       w_any_en;
    logic       w_xfer;
    logic       w_accept;
    logic [1:0] w_base;
    logic [1:0] w_nxt;
    logic [1:0] w_cand;
    logic       w_found;

`ifdef DEMUX_RR_CNT_EN
    logic [3:0][7:0] cnt_q, cnt_d;
`endif

    assign w_any_en = |ch_en;
    assign w_xfer   = (state_q == C_ST_SEND) && out_ready[sel_q];
    assign w_accept = in_valid && in_ready;

    // A completing transfer moves "last" to sel this cycle, so a back-to-back
    // accept must search from sel rather than the stale last register.
    assign w_base = w_xfer ? sel_q : last_q;

    always_comb begin
        w_nxt   = w_base;
        w_cand  = w_base;
        w_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            w_cand = w_base + 2'(i);
            if (!w_found && ch_en[w_cand]) begin
                w_nxt   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_ST_IDLE;
            data_q  <= '0;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
`ifdef DEMUX_RR_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
`ifdef DEMUX_RR_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        last_d  = last_q;
        if (w_xfer) begin
            last_d  = sel_q;
            state_d = C_ST_IDLE;
        end
        if (w_accept) begin
            data_d  = in_data;
            sel_d   = w_nxt;
            state_d = C_ST_SEND;
        end
    end

`ifdef DEMUX_RR_CNT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (w_xfer && (cnt_q[sel_q] != 8'hFF)) begin
            cnt_d[sel_q] = cnt_q[sel_q] + 8'd1;
        end
    end

    assign cnt = cnt_q;
`endif

    // Output logic
    always_comb begin
        out_valid = 4'b0000;
        if (state_q == C_ST_SEND) begin
            out_valid[sel_q] = 1'b1;
        end
        out_data = data_q;
        s0       = sel_q[0];
        s1       = sel_q[1];
        busy     = (state_q == C_ST_SEND);
        in_ready = w_any_en && ((state_q == C_ST_IDLE) || out_ready[sel_q]);
    end

endmodule
`default_nettype wire
